// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 register/icode constants, write-back entry type and scheduler FSM states
package y86_pkg;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RAX = 4'd0, RCX = 4'd1, RDX = 4'd2, RBX = 4'd3, RSP = 4'd4;
  localparam logic [3:0] RBP = 4'd5, RSI = 4'd6, RDI = 4'd7, R8 = 4'd8, R9 = 4'd9;
  localparam logic [3:0] R10 = 4'd10, R11 = 4'd11, R12 = 4'd12, R13 = 4'd13, R14 = 4'd14;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam int WB_W = 64;
  typedef struct packed {
    logic [3:0]      addr;
    logic [WB_W-1:0] data;
  } wb_entry_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} wbs_state_t;
endpackage

// File: rtl/wbs_fifo.sv
// wbs_fifo: circular register-write queue, 0/1/2 pushes and one pop per cycle, entries exposed oldest-first
module wbs_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push0,
  input  logic [3:0]    addr0,
  input  logic [W-1:0]  data0,
  input  logic          push1,
  input  logic [3:0]    addr1,
  input  logic [W-1:0]  data1,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [3:0]    q_addr [DEPTH],
  output logic [W-1:0]  q_data [DEPTH],
  output logic [DEPTH-1:0] q_valid
);
  logic [3:0]   addr_mem [DEPTH];
  logic [W-1:0] data_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push1 ? nxt(nxt(wr_ptr)) : push0 ? nxt(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push0) begin
      addr_mem[wr_ptr] <= addr0;
      data_mem[wr_ptr] <= data0;
    end
    if (push1) begin
      addr_mem[nxt(wr_ptr)] <= addr1;
      data_mem[nxt(wr_ptr)] <= data1;
    end
  end
  // Rotate so index 0 is the head and higher indices are younger
  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    logic [AW-1:0] idx;
    assign idx        = AW'((int'(rd_ptr) + i) % DEPTH);
    assign q_addr[i]  = addr_mem[idx];
    assign q_data[i]  = data_mem[idx];
    assign q_valid[i] = CW'(i) < count;
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: in-order single-port write-back queue with forwarding and drain; WBS_COALESCE_EN merges same-register E/M pairs
module regfile_wb_scheduler
  import y86_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REG_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [3:0]       wb_dstE,
  input  logic [REG_W-1:0] wb_valE,
  input  logic [3:0]       wb_dstM,
  input  logic [REG_W-1:0] wb_valM,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [REG_W-1:0] rf_wdata,
  input  logic [3:0]       rd_srcA,
  input  logic [3:0]       rd_srcB,
  input  logic [REG_W-1:0] rf_rdA,
  input  logic [REG_W-1:0] rf_rdB,
  output logic [REG_W-1:0] rd_valA,
  output logic [REG_W-1:0] rd_valB,
  input  logic             drain_req,
  output logic             drain_done,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH + 1);
  wbs_state_t state, state_nx;
  logic [CW-1:0]    count;
  logic [3:0]       q_addr [DEPTH];
  logic [REG_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic has_e, has_m, use_e, acc;
  int slots;
  assign has_e = wb_dstE != RNONE;
  assign has_m = wb_dstM != RNONE;
`ifdef WBS_COALESCE_EN
  logic same;
  assign same  = has_m && wb_dstE == wb_dstM;
  assign use_e = has_e && !same;
`else
  assign use_e = has_e;
`endif
  // A non-empty queue pops this cycle, so the head slot counts as free
  always_comb begin
    slots = DEPTH - int'(count) + int'(count != '0);
`ifdef WBS_COALESCE_EN
    wb_ready = state == RUN && (slots >= 2 || (same && slots >= 1));
`else
    wb_ready = state == RUN && slots >= 2;
`endif
  end
  assign acc = wb_valid && wb_ready;
  wbs_fifo #(.DEPTH(DEPTH), .W(REG_W)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push0(acc && (use_e || has_m)),
    .addr0(use_e ? wb_dstE : wb_dstM),
    .data0(use_e ? wb_valE : wb_valM),
    .push1(acc && use_e && has_m),
    .addr1(wb_dstM), .data1(wb_valM),
    .pop(rf_we),
    .count(count), .q_addr(q_addr), .q_data(q_data), .q_valid(q_valid)
  );
  assign rf_we    = q_valid[0];
  assign rf_waddr = rf_we ? q_addr[0] : '0;
  assign rf_wdata = rf_we ? q_data[0] : '0;
  always_comb begin
    rd_valA = rf_rdA;
    rd_valB = rf_rdB;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && q_addr[i] == rd_srcA) rd_valA = q_data[i];
      if (q_valid[i] && q_addr[i] == rd_srcB) rd_valB = q_data[i];
    end
    if (rd_srcA == RNONE) rd_valA = '0;
    if (rd_srcB == RNONE) rd_valB = '0;
  end
  always_ff @(posedge clk) state <= !rst_n ? RUN : state_nx;
  always_comb begin
    state_nx = state == RUN   ? (drain_req ? DRAIN : RUN) :
               state == DRAIN ? (count == '0 ? DONE : DRAIN) :
                                (drain_req ? DONE : RUN);
  end
  always_comb begin
    drain_done = state == DRAIN && count == '0;
    busy       = count != '0 || state != RUN;
  end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: scoreboard bench, expected writes queued at acceptance and compared by a negedge monitor
module tb_regfile_wb_scheduler;
  import y86_pkg::*;
  localparam int DEPTH = 4;
  localparam int REG_W = 64;
`ifdef WBS_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif
  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
  } wr_t;
  logic clk = 0, rst_n = 0, wb_valid = 0, wb_ready, drain_req = 0;
  logic [3:0] wb_dstE = RNONE, wb_dstM = RNONE, rd_srcA = RNONE, rd_srcB = RNONE;
  logic [REG_W-1:0] wb_valE = '0, wb_valM = '0, rf_rdA = '0, rf_rdB = '0;
  logic rf_we, drain_done, busy;
  logic [3:0] rf_waddr;
  logic [REG_W-1:0] rf_wdata, rd_valA, rd_valB;
  wr_t exp_wr[$];
  int checks = 0, errors = 0, mode = 0, n, slots;
  bit started = 0, post_rst = 0, m_rdy = 0, coal_req, seen;
  regfile_wb_scheduler #(.DEPTH(DEPTH), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_srcA(rd_srcA), .rd_srcB(rd_srcB), .rf_rdA(rf_rdA), .rf_rdB(rf_rdB),
    .rd_valA(rd_valA), .rd_valB(rd_valB),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask
  // Youngest pending write to src wins; otherwise the raw register-file value
  function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] raw);
    logic [63:0] v = raw;
    if (src == RNONE) return '0;
    foreach (exp_wr[i]) if (exp_wr[i].a == src) v = exp_wr[i].d;
    return v;
  endfunction
  always @(negedge clk) if (started) begin
    n = exp_wr.size();
    slots = DEPTH - n + (n != 0 ? 1 : 0);
    coal_req = COAL && wb_dstE == wb_dstM && wb_dstE != RNONE;
    m_rdy = mode == 0 && (slots >= 2 || (coal_req && slots >= 1));
    chk("wb_ready", 64'(wb_ready), 64'(m_rdy));
    chk("busy", 64'(busy), 64'(n != 0 || mode != 0));
    chk("drain_done", 64'(drain_done), 64'(mode == 1 && n == 0));
    chk("rf_we", 64'(rf_we), 64'(n != 0));
    if (n != 0) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(exp_wr[0].a));
      chk("rf_wdata", rf_wdata, exp_wr[0].d);
    end else if (post_rst) begin
      chk("rst_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_wdata", rf_wdata, 64'd0);
    end
    chk("rd_valA", rd_valA, fwd(rd_srcA, rf_rdA));
    chk("rd_valB", rd_valB, fwd(rd_srcB, rf_rdB));
    if (mode == 0 && drain_req) mode = 1;
    else if (mode == 1 && n == 0) mode = 2;
    else if (mode == 2 && !drain_req) mode = 0;
    if (n != 0) void'(exp_wr.pop_front());
    post_rst = !rst_n;
    if (!rst_n) begin
      exp_wr.delete();
      mode = 0;
      m_rdy = 0;
    end
  end
  // Record the writes a request should produce once the model says it is accepted
  always @(negedge clk) begin
    #1;
    if (started && rst_n && wb_valid && m_rdy) begin
      if (COAL && wb_dstE == wb_dstM && wb_dstE != RNONE) exp_wr.push_back('{wb_dstM, wb_valM});
      else begin
        if (wb_dstE != RNONE) exp_wr.push_back('{wb_dstE, wb_valE});
        if (wb_dstM != RNONE) exp_wr.push_back('{wb_dstM, wb_valM});
      end
    end
  end
  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
      rf_rdA = {$urandom, $urandom};
      rf_rdB = {$urandom, $urandom};
    end
  endtask
  task automatic req(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    wb_valid = 1;
    wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm;
    step();
    wb_valid = 0;
  endtask
  function automatic logic [3:0] pick();
    int r = $urandom_range(0, 5);
    return r == 5 ? RNONE : 4'(r);
  endfunction
  initial begin
    @(posedge clk);
    #1 started = 1;
    step();
    rst_n = 1;
    step();
    rd_srcA = 4'd3;
    req(4'd3, 64'h10, RNONE, 64'h0);
    step(2);
    rd_srcB = 4'd4;
    req(4'd4, 64'h100, 4'd4, 64'hAA);
    step(3);
    rd_srcA = 4'd4;
    wb_valid = 1;
    for (int i = 0; i < 6; i++) begin
      wb_dstE = 4'd4; wb_valE = 64'(i); wb_dstM = 4'd4; wb_valM = 64'(100 + i);
      step();
    end
    wb_valid = 0;
    step(5);
    req(4'd1, 64'h11, 4'd2, 64'h22);
    wb_valid = 1; wb_dstE = 4'd5; wb_valE = 64'h55; wb_dstM = 4'd6; wb_valM = 64'h66;
    drain_req = 1;
    step();
    wb_valid = 0;
    step(6);
    drain_req = 0;
    step(2);
    rd_srcA = 4'd7; rd_srcB = 4'd8;
    req(4'd7, 64'h77, 4'd8, 64'h88);
    rst_n = 0;
    step();
    rst_n = 1;
    step(2);
    req(4'd9, 64'h99, 4'd10, 64'hAA0);
    drain_req = 1;
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    drain_req = 0;
    step(2);
    rd_srcA = RNONE;
    req(4'd2, 64'h2222, RNONE, 64'h0);
    step(2);
    for (int c = 0; c < 3000; c++) begin
      wb_valid = $urandom_range(0, 3) != 0;
      wb_dstE = pick();
      wb_dstM = $urandom_range(0, 3) == 0 ? wb_dstE : pick();
      wb_valE = {$urandom, $urandom};
      wb_valM = {$urandom, $urandom};
      rd_srcA = pick();
      rd_srcB = pick();
      drain_req = drain_req ? $urandom_range(0, 3) != 0 : $urandom_range(0, 29) == 0;
      rst_n = $urandom_range(0, 299) != 0;
      step();
    end
    wb_valid = 0; rst_n = 1; drain_req = 0;
    step(2);
    drain_req = 1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      step();
      seen = drain_done;
    end
    chk("final_drain_done", 64'(seen), 64'd1);
    drain_req = 0;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
